prog_cache_ctrl: RTL and testbench

PROG_CACHE_CTRL -- requirements
Module: prog_cache_ctrl

---
 rtl/prog_cache_pkg.sv | 21 ++
 rtl/prog_cache_ram.sv | 25 ++
 rtl/prog_cache_ctrl.sv | 144 ++++++++++++++
 tb/tb_prog_cache_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_cache_pkg.sv
// Shared definitions for the program cache controller: default geometry,
// derived address-field widths and the controller state encoding.
package prog_cache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 64;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        INVAL = 2'd3
    } state_t;

endpackage

// File: rtl/prog_cache_ram.sv
// Instruction data store: one synchronous write port for line fills and one
// asynchronous read port so the fetched word follows the address in-cycle.
module prog_cache_ram #(
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter int DATA_W = prog_cache_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Fill write, one word per enabled clock; contents are left alone by reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_cache_ctrl.sv
// Direct-mapped program cache controller. Hits are answered combinationally
// from A; a miss latches the line address, requests a fill from SDRAM and
// stalls the core until the whole line has arrived. Invalidation walks the
// valid bits one line per cycle, deferred until any fill in flight is done.
module prog_cache_ctrl #(
    parameter int LINE_WORDS = prog_cache_pkg::LINE_WORDS,
    parameter int NUM_LINES  = prog_cache_pkg::NUM_LINES
) (
    input  logic                              clk,
    input  logic                              RST,
    input  logic [prog_cache_pkg::ADDR_W-1:0] A,
    output logic [prog_cache_pkg::DATA_W-1:0] I,
    output logic                              p_cache_miss,
    input  logic                              inval,
    output logic                              mem_req,
    output logic [prog_cache_pkg::ADDR_W-1:0] mem_addr,
    input  logic                              mem_ack,
    input  logic                              mem_valid,
    input  logic [prog_cache_pkg::DATA_W-1:0] mem_data
);
    import prog_cache_pkg::*;

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_W-1:0]     line_addr;
    logic [OFF_BITS-1:0]   word_cnt;
    logic [IDX_BITS-1:0]   inval_cnt;
    logic                  pending;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_BITS-1:0]   tags [NUM_LINES];

    logic [IDX_BITS-1:0]   a_idx;
    logic [IDX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]   a_tag;
    logic                  hit;
    logic                  fill_we;
    logic                  last_word;
    logic                  fill_done;
    logic                  inval_last;

    assign a_idx      = A[OFF_BITS +: IDX_BITS];
    assign a_tag      = A[ADDR_W-1 -: TAG_BITS];
    assign fill_idx   = line_addr[OFF_BITS +: IDX_BITS];
    assign hit        = valid[a_idx] && (tags[a_idx] == a_tag);
    assign fill_we    = (state == FILL) && mem_valid;
    assign last_word  = (word_cnt == OFF_BITS'(LINE_WORDS - 1));
    assign fill_done  = fill_we && last_word;
    assign inval_last = (inval_cnt == IDX_BITS'(NUM_LINES - 1));

    // State register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and output decode; the stall is released only on an IDLE hit.
    always_comb begin
        state_nx     = state;
        p_cache_miss = 1'b1;
        mem_req      = 1'b0;
        mem_addr     = '0;
        case (state)
            IDLE: begin
                p_cache_miss = !hit;
                if (pending || inval) state_nx = INVAL;
                else if (!hit)        state_nx = REQ;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = line_addr;
                if (mem_ack) state_nx = FILL;
            end
            FILL: begin
                if (fill_done) state_nx = IDLE;
            end
            INVAL: begin
                // A fresh inval pulse restarts the sweep, so never leave on it.
                if (inval_last && !inval) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Miss address latch, fill/sweep counters, pending flag and valid bits.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            line_addr <= '0;
            word_cnt  <= '0;
            inval_cnt <= '0;
            pending   <= 1'b0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nx == INVAL) begin
                        pending   <= 1'b0;
                        inval_cnt <= '0;
                    end else if (state_nx == REQ) begin
                        line_addr <= {A[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                    end
                end
                REQ: begin
                    if (inval) pending <= 1'b1;
                    word_cnt <= '0;
                end
                FILL: begin
                    if (inval) pending <= 1'b1;
                    if (fill_we) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) valid[fill_idx] <= 1'b1;
                    end
                end
                INVAL: begin
                    valid[inval_cnt] <= 1'b0;
                    inval_cnt        <= inval ? '0 : inval_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag written with the final fill word; no reset needed since valid gates it.
    always_ff @(posedge clk) begin
        if (fill_done) tags[fill_idx] <= line_addr[ADDR_W-1 -: TAG_BITS];
    end

    prog_cache_ram #(
        .DEPTH  (NUM_LINES * LINE_WORDS),
        .AW     (IDX_BITS + OFF_BITS),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (fill_we),
        .waddr ({fill_idx, word_cnt}),
        .wdata (mem_data),
        .raddr (A[IDX_BITS+OFF_BITS-1:0]),
        .rdata (I)
    );

endmodule

// File: tb/tb_prog_cache_ctrl.sv
// Self-checking bench for prog_cache_ctrl: directed scenarios plus a
// randomized run, all checked against a line-level cache model.
module tb_prog_cache_ctrl;
    import prog_cache_pkg::*;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] A;
    logic [15:0] I;
    logic        p_cache_miss;
    logic        inval;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        mem_valid;
    logic [15:0] mem_data;

    int checks = 0;
    int fails  = 0;

    logic [15:0]      fw [LINE_WORDS];
    bit               model_valid [NUM_LINES];
    logic [TAG_W-1:0] model_tag   [NUM_LINES];
    logic [15:0]      model_data  [NUM_LINES*LINE_WORDS];

    prog_cache_ctrl dut (
        .clk          (clk),
        .RST          (RST),
        .A            (A),
        .I            (I),
        .p_cache_miss (p_cache_miss),
        .inval        (inval),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    function automatic int line_of(input logic [15:0] a);
        return (int'(a) / LINE_WORDS) % NUM_LINES;
    endfunction
    function automatic int tag_of(input logic [15:0] a);
        return int'(a) / (LINE_WORDS * NUM_LINES);
    endfunction
    function automatic int off_of(input logic [15:0] a);
        return int'(a) % LINE_WORDS;
    endfunction
    function automatic bit model_hit(input logic [15:0] a);
        return model_valid[line_of(a)] && (model_tag[line_of(a)] == TAG_W'(tag_of(a)));
    endfunction
    function automatic logic [15:0] model_word(input logic [15:0] a);
        return model_data[line_of(a) * LINE_WORDS + off_of(a)];
    endfunction
    function automatic logic [15:0] line_base(input logic [15:0] a);
        return 16'(int'(a) - off_of(a));
    endfunction

    task automatic model_fill(input logic [15:0] a);
        model_valid[line_of(a)] = 1'b1;
        model_tag[line_of(a)]   = TAG_W'(tag_of(a));
        for (int k = 0; k < LINE_WORDS; k++) model_data[line_of(a) * LINE_WORDS + k] = fw[k];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_LINES; i++) model_valid[i] = 1'b0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < LINE_WORDS; k++) fw[k] = 16'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] a);
        RST = 1'b1; inval = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        step();
        step();
        A   = a;
        RST = 1'b0;
        model_clear();
    endtask

    // Plays the SDRAM side of one line fill starting from the REQ state.
    task automatic serve_fill(input int ack_delay, input int gap, input int inval_word);
        for (int d = 0; d < ack_delay; d++) begin A = 16'($urandom); step(); end
        mem_ack = 1'b1; A = 16'($urandom); step(); mem_ack = 1'b0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            int idle;
            idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int g = 0; g < idle; g++) begin mem_valid = 1'b0; A = 16'($urandom); step(); end
            mem_valid = 1'b1; mem_data = fw[k]; inval = (k == inval_word); A = 16'($urandom);
            step();
            inval = 1'b0;
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; inval = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        for (int n = 0; n < 4; n++) begin
            A = 16'($urandom);
            #1;
            checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL reset_miss: A=%h got %b want 1", A, p_cache_miss); end
            checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
            checks++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
            step();
        end
    endtask

    task automatic test_cold_miss();
        do_reset(16'h0102);
        #1;
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL cold_miss: got %b want 1", p_cache_miss); end
        step();
        checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL cold_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 16'h0100) begin fails++; $display("FAIL cold_addr: got %h want 0100", mem_addr); end
        A = 16'($urandom);
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin fails++; $display("FAIL cold_req_hold: got %b/%h want 1/0100", mem_req, mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin fails++; $display("FAIL cold_req_drop: got %b/%h want 0/0000", mem_req, mem_addr); end
        fw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        for (int k = 0; k < LINE_WORDS; k++) begin
            mem_valid = 1'b1; mem_data = fw[k]; A = 16'($urandom);
            #1;
            checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL cold_fill_stall: word %0d got %b want 1", k, p_cache_miss); end
            step();
        end
        mem_valid = 1'b0;
        model_fill(16'h0100);
        A = 16'h0102;
        #1;
        checks++; if (p_cache_miss !== 1'b0) begin fails++; $display("FAIL cold_done_miss: got %b want 0", p_cache_miss); end
        checks++; if (I !== 16'h0033) begin fails++; $display("FAIL cold_done_I: got %h want 0033", I); end
        step();
    endtask

    task automatic test_hit_after_fill();
        for (int k = 0; k < LINE_WORDS; k++) begin
            A = 16'h0100 + 16'(k);
            #1;
            checks++; if (p_cache_miss !== 1'b0) begin fails++; $display("FAIL hit_miss: A=%h got %b want 0", A, p_cache_miss); end
            checks++; if (I !== 16'h0011 * 16'(k + 1)) begin fails++; $display("FAIL hit_I: A=%h got %h want %h", A, I, 16'h0011 * 16'(k + 1)); end
            checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL hit_mem_req: got %b want 0", mem_req); end
            step();
        end
    endtask

    task automatic test_conflict();
        A = 16'h0200;
        #1;
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL conflict_miss: got %b want 1", p_cache_miss); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin fails++; $display("FAIL conflict_req: got %b/%h want 1/0200", mem_req, mem_addr); end
        rand_words();
        serve_fill(1, 0, -1);
        model_fill(16'h0200);
        A = 16'h0201;
        #1;
        checks++; if (p_cache_miss !== 1'b0 || I !== model_word(16'h0201)) begin fails++; $display("FAIL conflict_hit: got %b/%h want 0/%h", p_cache_miss, I, model_word(16'h0201)); end
        A = 16'h0100;
        #1;
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL conflict_evict: got %b want 1", p_cache_miss); end
        step();
        checks++; if (mem_addr !== 16'h0100) begin fails++; $display("FAIL conflict_refetch: got %h want 0100", mem_addr); end
        fw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        serve_fill(0, 0, -1);
        model_fill(16'h0100);
        A = 16'h0100;
        #1;
        checks++; if (p_cache_miss !== 1'b0 || I !== 16'h0011) begin fails++; $display("FAIL conflict_restore: got %b/%h want 0/0011", p_cache_miss, I); end
        step();
    endtask

    task automatic test_gapped_fill();
        A = 16'h0304;
        #1;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0304) begin fails++; $display("FAIL gap_req: got %b/%h want 1/0304", mem_req, mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        rand_words();
        for (int k = 0; k < LINE_WORDS; k++) begin
            mem_valid = 1'b0;
            step();
            checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL gap_stall: after gap %0d got %b want 1", k, p_cache_miss); end
            mem_valid = 1'b1; mem_data = fw[k];
            step();
        end
        mem_valid = 1'b0;
        model_fill(16'h0304);
        for (int k = 0; k < LINE_WORDS; k++) begin
            A = 16'h0304 + 16'(k);
            #1;
            checks++; if (p_cache_miss !== 1'b0 || I !== fw[k]) begin fails++; $display("FAIL gap_word: off %0d got %b/%h want 0/%h", k, p_cache_miss, I, fw[k]); end
            step();
        end
    endtask

    task automatic test_inval_during_fill();
        int cnt;
        A = 16'h0508;
        #1;
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL invfill_miss: got %b want 1", p_cache_miss); end
        step();
        checks++; if (mem_addr !== 16'h0508) begin fails++; $display("FAIL invfill_req: got %h want 0508", mem_addr); end
        rand_words();
        serve_fill(0, 0, 2);
        model_fill(16'h0508);
        // One IDLE cycle, NUM_LINES sweep cycles, one IDLE cycle, then the new request.
        A = 16'h0100;
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 200) begin step(); cnt++; end
        model_clear();
        checks++; if (cnt != NUM_LINES + 2) begin fails++; $display("FAIL invfill_len: got %0d cycles want %0d", cnt, NUM_LINES + 2); end
        checks++; if (mem_addr !== 16'h0100) begin fails++; $display("FAIL invfill_refetch: got %h want 0100", mem_addr); end
        fw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        serve_fill(0, 0, -1);
        model_fill(16'h0100);
        A = 16'h0508;
        #1;
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL invfill_cleared: got %b want 1", p_cache_miss); end
        step();
        rand_words();
        serve_fill(0, 1, -1);
        model_fill(16'h0508);
    endtask

    task automatic test_inval_restart();
        int cnt;
        A = 16'h0100;
        #1;
        checks++; if (p_cache_miss !== 1'b0) begin fails++; $display("FAIL restart_pre_hit: got %b want 0", p_cache_miss); end
        inval = 1'b1;
        step();
        inval = 1'b0;
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 300) begin
            inval = (cnt == 9);
            step();
            cnt++;
        end
        inval = 1'b0;
        model_clear();
        checks++; if (cnt != 10 + NUM_LINES + 1) begin fails++; $display("FAIL restart_len: got %0d cycles want %0d", cnt, 10 + NUM_LINES + 1); end
        checks++; if (mem_addr !== 16'h0100) begin fails++; $display("FAIL restart_refetch: got %h want 0100", mem_addr); end
        fw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        serve_fill(0, 0, -1);
        model_fill(16'h0100);
    endtask

    task automatic test_reset_mid_fill();
        A = 16'h0610;
        #1;
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        rand_words();
        for (int k = 0; k < 2; k++) begin mem_valid = 1'b1; mem_data = fw[k]; step(); end
        mem_valid = 1'b0;
        RST = 1'b1;
        A = 16'h0100;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) begin fails++; $display("FAIL rstfill_req: got %b/%h want 0/0000", mem_req, mem_addr); end
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL rstfill_miss: got %b want 1", p_cache_miss); end
        step();
        RST = 1'b0;
        model_clear();
        mem_valid = 1'b1; mem_data = 16'hDEAD;
        #1;
        checks++; if (p_cache_miss !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rstfill_idle: got %b/%b want 1/0", p_cache_miss, mem_req); end
        step();
        mem_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin fails++; $display("FAIL rstfill_newreq: got %b/%h want 1/0100", mem_req, mem_addr); end
        rand_words();
        serve_fill(0, 0, -1);
        model_fill(16'h0100);
        for (int k = 0; k < LINE_WORDS; k++) begin
            A = 16'h0100 + 16'(k);
            #1;
            checks++; if (p_cache_miss !== 1'b0 || I !== fw[k]) begin fails++; $display("FAIL rstfill_word: off %0d got %b/%h want 0/%h", k, p_cache_miss, I, fw[k]); end
            step();
        end
        A = 16'h0610;
        #1;
        checks++; if (p_cache_miss !== 1'b1) begin fails++; $display("FAIL rstfill_abandoned: got %b want 1", p_cache_miss); end
        step();
        rand_words();
        serve_fill(0, 0, -1);
        model_fill(16'h0610);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            bit          exp_hit;
            bit          do_inv;
            a = 16'(($urandom_range(1, 4) << (OFF_W + IDX_W)) + ($urandom_range(0, 7) << OFF_W) + $urandom_range(0, LINE_WORDS - 1));
            A = a;
            #1;
            exp_hit = model_hit(a);
            checks++; if (p_cache_miss !== !exp_hit) begin fails++; $display("FAIL rand_miss: A=%h got %b want %b", a, p_cache_miss, !exp_hit); end
            if (exp_hit) begin
                checks++; if (I !== model_word(a)) begin fails++; $display("FAIL rand_I: A=%h got %h want %h", a, I, model_word(a)); end
                step();
            end else begin
                step();
                checks++; if (mem_req !== 1'b1 || mem_addr !== line_base(a)) begin fails++; $display("FAIL rand_req: got %b/%h want 1/%h", mem_req, mem_addr, line_base(a)); end
                rand_words();
                do_inv = ($urandom_range(0, 7) == 0);
                serve_fill(int'($urandom_range(0, 3)), -1, do_inv ? int'($urandom_range(0, LINE_WORDS - 1)) : -1);
                model_fill(a);
                A = a;
                #1;
                checks++; if (p_cache_miss !== 1'b0 || I !== model_word(a)) begin fails++; $display("FAIL rand_fill: A=%h got %b/%h want 0/%h", a, p_cache_miss, I, model_word(a)); end
                if (do_inv) begin
                    for (int c = 0; c < NUM_LINES + 1; c++) step();
                    model_clear();
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        A = '0;
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_conflict();
        test_gapped_fill();
        test_inval_during_fill();
        test_inval_restart();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
